// File: rtl/robin_uart_pkg.sv
// Shared UART receive types and baud-timing helpers; no logic, no latency.
// Consumed by uart_rx_fifo for the FSM encoding and cycles-per-bit constants.
package robin_uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_t;

   function automatic int calc_cpb(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int calc_half(input int clk_hz, input int baud);
      return calc_cpb(clk_hz, baud) / 2;
   endfunction

endpackage

// File: rtl/robin_sync_fifo.sv
// First-word-fall-through FIFO, 2**AW entries; a push shows at head one cycle later.
// A push while full is ignored unless a pop lands in the same cycle; a pop while empty is ignored.
module robin_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // When full, a same-cycle pop frees the slot at wr_ptr (== rd_ptr) for the new byte.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver into a FWFT byte FIFO; stop bit sampled HALF+9*CPB cycles after rx_s falls, VALID the cycle after.
// The line cannot be stalled: a byte arriving to a full FIFO with no same-cycle READ is dropped and OVERRUN pulses.
module uart_rx_fifo
   import robin_uart_pkg::*;
#(
   parameter int CLK_HZ  = 12000000,
   parameter int BAUD    = 115200,
   parameter int FIFO_AW = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RX,
   output logic [BYTE_W-1:0] DATA,
   output logic              VALID,
   input  logic              READ,
   output logic [FIFO_AW:0]  COUNT,
   output logic              FRAMING_ERR,
   output logic              OVERRUN
);

   localparam int CPB  = calc_cpb(CLK_HZ, BAUD);
   localparam int HALF = calc_half(CLK_HZ, BAUD);
   localparam int CW   = $clog2(CPB);
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

   logic              rx_m;
   logic              rx_s;
   rx_state_t         state;
   rx_state_t         state_n;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_n;
   logic [2:0]        idx;
   logic [2:0]        idx_n;
   logic [BYTE_W-1:0] shreg;
   logic [BYTE_W-1:0] shreg_n;
   logic              push;
   logic              ferr_n;
   logic              full;
   logic              empty;

   // Idle-high reset value keeps a reset release from looking like a start edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= RX;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         FRAMING_ERR <= 1'b0;
         OVERRUN     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         shreg       <= shreg_n;
         FRAMING_ERR <= ferr_n;
         OVERRUN     <= push && full && !(READ && !empty);
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      idx_n   = idx;
      shreg_n = shreg;
      push    = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = ST_START;
         end
         ST_START: begin
            if (cnt == CNT_MID) begin
               cnt_n = '0;
               idx_n = '0;
               state_n = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            // LSB arrives first, so each new bit enters at the top and walks down.
            if (cnt == CNT_LAST) begin
               cnt_n   = '0;
               shreg_n = {rx_s, shreg[BYTE_W-1:1]};
               idx_n   = idx + 3'd1;
               if (idx == 3'd7) state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
               push    = rx_s;
               ferr_n  = !rx_s;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   robin_sync_fifo #(
      .WIDTH (BYTE_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (push),
      .push_data (shreg),
      .pop       (READ),
      .head      (DATA),
      .count     (COUNT),
      .full      (full),
      .empty     (empty)
   );

   assign VALID = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised frame bench for uart_rx_fifo against a queue model timed from the line rate.
module tb_uart_rx_fifo;

   localparam int CPB   = 12000000 / 115200;
   localparam int HALF  = CPB / 2;
   // RX driven before edge N+1 -> rx_s low after N+2 -> FSM sees it at N+3; stop sample HALF+9*CPB later.
   localparam int LAT   = 3 + HALF + 9 * CPB;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX = 1'b1;
   logic       READ = 1'b0;
   logic [7:0] DATA;
   logic       VALID;
   logic [4:0] COUNT;
   logic       FRAMING_ERR;
   logic       OVERRUN;

   always #5 CLK = ~CLK;

   uart_rx_fifo #(.CLK_HZ(12000000), .BAUD(115200), .FIFO_AW(4)) dut (
      .CLK(CLK), .RST(RST), .RX(RX), .DATA(DATA), .VALID(VALID), .READ(READ),
      .COUNT(COUNT), .FRAMING_ERR(FRAMING_ERR), .OVERRUN(OVERRUN)
   );

   typedef struct {
      int         at;
      logic [7:0] b;
      logic       ok;
   } ev_t;

   ev_t        pend[$];
   int         pend_rd = 0;
   logic [7:0] q[$];
   int         cyc = 0;
   logic       ferr_m = 1'b0;
   logic       ovr_m = 1'b0;
   logic       m_pop;
   logic       m_full;

   always @(posedge CLK) begin
      cyc = cyc + 1;
      ferr_m = 1'b0;
      ovr_m = 1'b0;
      if (RST) begin
         q.delete();
         pend_rd = pend.size();
      end else begin
         m_full = (q.size() == 16);
         m_pop = READ && (q.size() != 0);
         if (m_pop) void'(q.pop_front());
         if (pend_rd < pend.size() && pend[pend_rd].at == cyc) begin
            if (!pend[pend_rd].ok) ferr_m = 1'b1;
            else if (m_full && !m_pop) ovr_m = 1'b1;
            else q.push_back(pend[pend_rd].b);
            pend_rd++;
         end
      end
   end

   int   passed = 0;
   int   checks = 0;
   int   ferr_seen = 0;
   int   ovr_seen = 0;
   int   valid_cyc = -1;
   int   rd_mode = 0;
   int   rd_at = 0;
   int   n0;
   logic cmp_en = 1'b0;

   function automatic logic [7:0] mhead();
      if (q.size() == 0) return 8'h00;
      return q[0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Drive one cycle of inputs at a falling edge, then compare at the next falling edge.
   task automatic step(input logic rx_v);
      RX = rx_v;
      case (rd_mode)
         1:       READ = ($urandom_range(0, 3) == 0);
         2:       READ = (cyc + 1 == rd_at);
         3:       READ = 1'b1;
         default: READ = 1'b0;
      endcase
      @(negedge CLK);
      if (cmp_en)
         chk("cycle", {16'h0, VALID, COUNT, (VALID ? DATA : 8'h00), FRAMING_ERR, OVERRUN},
             {16'h0, (q.size() != 0), 5'(q.size()), mhead(), ferr_m, ovr_m});
      if (FRAMING_ERR) ferr_seen++;
      if (OVERRUN) ovr_seen++;
      if (VALID && valid_cyc < 0) valid_cyc = cyc;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic ok, input int abort);
      logic [9:0] bits;
      bits = {ok, b, 1'b0};
      pend.push_back('{cyc + LAT, b, ok});
      for (int k = 0; k < 10 * CPB; k++) begin
         if (abort > 0 && k == abort) return;
         if (!ok && k >= 9 * CPB + 60) step(1'b1);
         else step(bits[k / CPB]);
      end
      // A low stop bit re-triggers a start; give the glitch filter time to reject it.
      if (!ok) repeat (CPB) step(1'b1);
   endtask

   initial begin
      repeat (3) step(1'b1);
      chk("rst_data", 32'(DATA), 32'h0);
      chk("rst_valid", 32'(VALID), 32'h0);
      chk("rst_count", 32'(COUNT), 32'h0);
      chk("rst_ferr", 32'(FRAMING_ERR), 32'h0);
      chk("rst_ovr", 32'(OVERRUN), 32'h0);
      RST = 1'b0;
      cmp_en = 1'b1;
      repeat (5) step(1'b1);

      n0 = cyc;
      valid_cyc = -1;
      send_frame(8'hA5, 1'b1, 0);
      chk("latency", 32'(valid_cyc - (n0 + 2)), 32'd989);
      chk("a5_data", 32'(DATA), 32'hA5);
      chk("a5_count", 32'(COUNT), 32'd1);
      rd_mode = 3;
      step(1'b1);
      rd_mode = 0;
      chk("a5_pop_valid", 32'(VALID), 32'h0);
      chk("a5_pop_count", 32'(COUNT), 32'h0);

      ferr_seen = 0;
      ovr_seen = 0;
      repeat (20) step(1'b0);
      repeat (2 * CPB) step(1'b1);
      chk("glitch_count", 32'(COUNT), 32'h0);
      chk("glitch_ferr", 32'(ferr_seen), 32'h0);
      chk("glitch_ovr", 32'(ovr_seen), 32'h0);

      ferr_seen = 0;
      send_frame(8'h3C, 1'b0, 0);
      chk("ferr_pulses", 32'(ferr_seen), 32'd1);
      chk("ferr_count", 32'(COUNT), 32'h0);

      ovr_seen = 0;
      for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 0);
      chk("full_count", 32'(COUNT), 32'd16);
      chk("ovr_pulses", 32'(ovr_seen), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("order", 32'(DATA), 32'(i));
         rd_mode = 3;
         step(1'b1);
      end
      rd_mode = 0;
      step(1'b1);
      chk("drained_valid", 32'(VALID), 32'h0);
      rd_mode = 3;
      repeat (5) step(1'b1);
      rd_mode = 0;
      chk("underflow_count", 32'(COUNT), 32'h0);

      for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 0);
      ovr_seen = 0;
      rd_at = cyc + LAT;
      rd_mode = 2;
      send_frame(8'h10, 1'b1, 0);
      rd_mode = 0;
      chk("swap_ovr", 32'(ovr_seen), 32'h0);
      chk("swap_count", 32'(COUNT), 32'd16);
      for (int i = 0; i < 16; i++) begin
         chk("swap_order", 32'(DATA), 32'(i + 1));
         rd_mode = 3;
         step(1'b1);
      end
      rd_mode = 0;
      step(1'b1);

      rd_mode = 1;
      repeat (16) begin
         send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 0);
         repeat ($urandom_range(0, 20)) step(1'b1);
      end
      rd_mode = 3;
      repeat (20) step(1'b1);
      rd_mode = 0;
      chk("rand_drained", 32'(COUNT), 32'h0);

      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b1, 0);
      send_frame(8'h33, 1'b1, 0);
      chk("pre_rst_count", 32'(COUNT), 32'd3);
      send_frame(8'h5A, 1'b1, 5 * CPB + 50);
      RST = 1'b1;
      step(1'b1);
      RST = 1'b0;
      chk("midrst_count", 32'(COUNT), 32'h0);
      chk("midrst_valid", 32'(VALID), 32'h0);
      repeat (2 * CPB) step(1'b1);
      chk("post_rst_idle", 32'(COUNT), 32'h0);
      send_frame(8'hFF, 1'b1, 0);
      chk("ff_data", 32'(DATA), 32'hFF);
      chk("ff_count", 32'(COUNT), 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receive stage feeding the robin SoC core from the board RX pin. It synchronises RX and recovers 8N1 frames at a fixed baud rate. Received bytes are buffered in a small FIFO and presented to the core through a valid/read handshake. Framing errors and overruns are reported as single-cycle pulses.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz (IceBreaker oscillator).
BAUD, 115200, line rate in bits/s.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
RX  input  1  asynchronous serial line; idle high.
DATA  output  8  head-of-FIFO byte; valid only while VALID=1.
VALID  output  1  FIFO non-empty.
READ  input  1  pop request; honoured only when VALID=1.
COUNT  output  FIFO_AW+1  number of bytes currently held (0..16).
FRAMING_ERR  output  1  one-cycle pulse: stop bit sampled low.
OVERRUN  output  1  one-cycle pulse: byte dropped because FIFO full.

Behaviour:
- Interface fact: one clock, CLK; reset RST is synchronous and active-high.
- Constants: CPB = CLK_HZ/BAUD, truncated (104 at defaults); HALF = CPB/2 (52).
- RX passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised bit rx_s.
- Bit counter: 0..CPB-1, wraps to 0 on each terminal count. Bit index: 3 bits.
- FSM states:
  - IDLE: on rx_s==0, go to START with counter=0.
  - START: at counter==HALF-1, sample rx_s. If 0, go to DATA with counter=0 and index=0. If 1 (glitch), go to IDLE.
  - DATA: at counter==CPB-1, shift rx_s into the MSB of the shift register (LSB received first) and increment the index. After the sample at index 7, go to STOP.
  - STOP: at counter==CPB-1, sample rx_s and go to IDLE.
    - rx_s==1: push the byte.
    - rx_s==0: FRAMING_ERR=1 for that cycle; byte discarded.
- Push rules:
  - Push to a non-full FIFO: COUNT+1; VALID/DATA update on the next cycle.
  - Full FIFO without same-cycle READ: byte dropped, OVERRUN=1 for one cycle, contents unchanged.
  - Full FIFO with same-cycle READ: pop and push both occur; COUNT stays 16; no OVERRUN.
- FIFO is first-word-fall-through: DATA = oldest byte whenever VALID=1.
- READ while VALID=0 is ignored; no underflow, COUNT stays 0.
- Simultaneous push and pop on a non-empty FIFO: COUNT unchanged.
- Read and write pointers are FIFO_AW bits and wrap modulo depth.
- Latency: the stop-bit sample occurs HALF + 9*CPB cycles after rx_s first reads 0 (988 at defaults). VALID rises the following cycle.
- Back-to-back frames: IDLE at mid-stop detects the next start edge with no gap required.
- Reset values: DATA=0, VALID=0, COUNT=0, FRAMING_ERR=0, OVERRUN=0, FSM=IDLE, pointers=0, shift register=0.
- RST asserted mid-frame: partial byte abandoned; FIFO flushed. The next frame is received only after a new falling edge following deassertion.

Decomposition:
- Shared package robin_uart_pkg:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Functions computing CPB and HALF from CLK_HZ/BAUD.
  - Byte width constant 8.
- One sub-module, robin_sync_fifo:
  - Parameterised by width and FIFO_AW; first-word-fall-through.
  - Ports: push, push_data, pop, head data, count, full, empty.
  - Overrun detection stays in uart_rx_fifo.

Test Plan:
- Frame 0xA5 at 104 cycles/bit, stop=1 -> VALID rises 989 cycles after rx_s falls; DATA=0xA5; COUNT=1. Pulse READ one cycle -> VALID=0, COUNT=0.
- RX low for 20 cycles, then high -> FSM returns to IDLE; no push; FRAMING_ERR and OVERRUN never assert.
- Frame 0x3C with stop bit low -> FRAMING_ERR high for exactly one cycle; COUNT stays 0.
- 17 frames 0x00..0x10, no READ -> COUNT=16 and OVERRUN pulses once on the 17th frame. Reading 16 times yields 0x00..0x0F in order; then VALID=0.
- FIFO full; assert READ in the exact cycle the 17th stop bit is sampled -> no OVERRUN; COUNT stays 16; last entry read out is 0x10.
- Assert RST during bit 4 of a frame, with 3 bytes already queued -> next cycle COUNT=0, VALID=0. A subsequent clean 0xFF frame is received correctly.
